// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: shares one single-port data memory between the instruction
// fetch port (A, read-only) and the load/store port (B, read/write).
// Contention is resolved round-robin. Each access takes IDLE -> ACCESS -> RESP,
// and the owner's ack pulses in RESP.
//
// Ports:
//   clk, reset_n              clock (posedge logic), async active-low reset
//   a_req/a_addr              fetch request and word address
//   a_ack/a_rdata             fetch completion pulse and fetched word
//   b_req/b_we/b_addr/b_wdata load/store request, direction, address, data
//   b_ack/b_rdata             load/store completion pulse and loaded word
//   mem_address/mem_data_in   registered memory address and write data
//   mem_write                 registered memory write enable
//   mem_data_out              combinational memory read data
//   busy                      high whenever the FSM is outside IDLE
module mem_arbiter_2p #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 a_req,
  input  logic [BITS_ADDR-1:0] a_addr,
  output logic                 a_ack,
  output logic [BITS_DATA-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [BITS_ADDR-1:0] b_addr,
  input  logic [BITS_DATA-1:0] b_wdata,
  output logic                 b_ack,
  output logic [BITS_DATA-1:0] b_rdata,
  output logic [BITS_ADDR-1:0] mem_address,
  output logic [BITS_DATA-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_data_out,
  output logic                 busy
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic owner_q;
  logic owner_d;
  logic last_grant_q;
  logic last_grant_d;

  logic                 a_ack_d;
  logic                 b_ack_d;
  logic [BITS_DATA-1:0] a_rdata_d;
  logic [BITS_DATA-1:0] b_rdata_d;
  logic [BITS_ADDR-1:0] mem_address_d;
  logic [BITS_DATA-1:0] mem_data_in_d;
  logic                 mem_write_d;
  logic                 busy_d;

  logic any_req;
  logic grant_b;

  // B wins when it is alone, or on a tie when A was granted last.
  assign any_req = a_req | b_req;
  assign grant_b = b_req & (~a_req | (last_grant_q == PORT_A));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    a_rdata_d     = a_rdata;
    b_rdata_d     = b_rdata;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
    mem_write_d   = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d      = grant_b;
          last_grant_d = grant_b;
          if (grant_b) begin
            mem_address_d = b_addr;
            mem_data_in_d = b_wdata;
            mem_write_d   = b_we;
          end else begin
            mem_address_d = a_addr;
          end
        end
      end
      ST_ACCESS: begin
        // mem_write still holds the latched direction here; capture on reads only.
        if (owner_q == PORT_B) begin
          b_ack_d = 1'b1;
          if (!mem_write) b_rdata_d = mem_data_out;
        end else begin
          a_ack_d   = 1'b1;
          a_rdata_d = mem_data_out;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_write    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_ack        <= a_ack_d;
      b_ack        <= b_ack_d;
      a_rdata      <= a_rdata_d;
      b_rdata      <= b_rdata_d;
      mem_address  <= mem_address_d;
      mem_data_in  <= mem_data_in_d;
      mem_write    <= mem_write_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Testbench for mem_arbiter_2p with a behavioural memory (async read,
// write on falling edge) and a queue of expected read data.
module tb_mem_arbiter_2p;

  localparam int unsigned BD = 32;
  localparam int unsigned BA = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req;
  logic [BA-1:0] a_addr;
  logic          a_ack;
  logic [BD-1:0] a_rdata;
  logic          b_req;
  logic          b_we;
  logic [BA-1:0] b_addr;
  logic [BD-1:0] b_wdata;
  logic          b_ack;
  logic [BD-1:0] b_rdata;
  logic [BA-1:0] mem_address;
  logic [BD-1:0] mem_data_in;
  logic          mem_write;
  logic [BD-1:0] mem_data_out;
  logic          busy;

  // Backdoor preload port of the memory model.
  logic          bd_we = 1'b0;
  logic [BA-1:0] bd_addr = '0;
  logic [BD-1:0] bd_data = '0;

  logic [BD-1:0] mem [0:65535];
  logic [BD-1:0] ref_mem [int];
  logic [BD-1:0] exp_q [$];
  bit            exp_port_q [$];
  logic [BD-1:0] exp_b_rdata;

  int checks = 0;
  int passed = 0;
  int write_cycles = 0;

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address];

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      mem[mem_address] <= mem_data_in;
      write_cycles     <= write_cycles + 1;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end

  mem_arbiter_2p #(.BITS_DATA(BD), .BITS_ADDR(BA)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a_req        (a_req),
    .a_addr       (a_addr),
    .a_ack        (a_ack),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_rdata      (b_rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  task automatic preload(input logic [BA-1:0] addr, input logic [BD-1:0] data);
    bd_addr = addr;
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    #1 bd_we = 1'b0;
    ref_mem[int'(addr)] = data;
  endtask

  // Issues one request from an IDLE FSM and waits (bounded) for its ack.
  task automatic do_access(input bit port_b, input logic we, input logic [BA-1:0] addr,
                           input logic [BD-1:0] wdata, output bit got, output int lat,
                           output logic [BD-1:0] rdata);
    got   = 1'b0;
    lat   = 0;
    rdata = 'x;
    if (port_b) begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      a_addr = addr; a_req = 1'b1;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (port_b ? b_ack : a_ack) begin
        got   = 1'b1;
        rdata = port_b ? b_rdata : a_rdata;
      end
    end
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    reset_n = 1'b0;
    a_req = 1'b1; a_addr = 16'h0001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0002; b_wdata = '0;
    preload(16'h0001, 32'h0100_5555);
    preload(16'h0000, 32'h1111_0000);
    preload(16'h0002, 32'h2222_0002);
    preload(16'h0010, 32'hCAFE_F00D);
    @(posedge clk); #1;
    checks++;
    if ({a_ack, b_ack, mem_write, busy} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {a_ack, b_ack, mem_write, busy});
    else passed++;
    checks++;
    if (mem_address !== '0 || mem_data_in !== '0) $display("FAIL reset_mem_bus: addr %h data %h want 0", mem_address, mem_data_in);
    else passed++;
    checks++;
    if (a_rdata !== '0 || b_rdata !== '0) $display("FAIL reset_rdata: a %h b %h want 0", a_rdata, b_rdata);
    else passed++;
    exp_b_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(ref_mem[1]);
    lat = 0;
    while (lat < 10 && a_ack !== 1'b1 && b_ack !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0) $display("FAIL reset_first_grant: a_ack %b b_ack %b want a_ack=1", a_ack, b_ack);
    else passed++;
    checks++;
    if (lat !== 2) $display("FAIL reset_latency: got %0d want 2", lat);
    else passed++;
    checks++;
    if (a_rdata !== exp_q[0]) $display("FAIL reset_a_rdata: got %h want %h", a_rdata, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_a_read();
    bit got; int lat; logic [BD-1:0] rd; int wc0;
    wc0 = write_cycles;
    exp_q.push_back(ref_mem[1]);
    do_access(1'b0, 1'b0, 16'h0001, '0, got, lat, rd);
    checks++;
    if (!got) $display("FAIL a_read_ack: no ack within bound");
    else passed++;
    checks++;
    if (rd !== exp_q[0]) $display("FAIL a_read_data: got %h want %h", rd, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    checks++;
    if (lat !== 2) $display("FAIL a_read_latency: got %0d want 2", lat);
    else passed++;
    checks++;
    if (write_cycles !== wc0) $display("FAIL a_read_no_write: %0d write cycles want 0", write_cycles - wc0);
    else passed++;
  endtask

  task automatic test_b_write_read();
    bit got; int lat; logic [BD-1:0] rd;
    exp_q.push_back(exp_b_rdata);
    do_access(1'b1, 1'b1, 16'h0040, 32'hDEAD_BEEF, got, lat, rd);
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    checks++;
    if (!got) $display("FAIL b_write_ack: no ack within bound");
    else passed++;
    checks++;
    if (rd !== exp_q[0]) $display("FAIL b_write_rdata_kept: got %h want %h", rd, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    exp_q.push_back(ref_mem[32'h40]);
    do_access(1'b1, 1'b0, 16'h0040, '0, got, lat, rd);
    checks++;
    if (rd !== exp_q[0]) $display("FAIL b_read_back: got %h want %h", rd, exp_q[0]);
    else passed++;
    exp_b_rdata = exp_q.pop_front();
    checks++;
    if (a_rdata !== ref_mem[1]) $display("FAIL a_rdata_hold: got %h want %h", a_rdata, ref_mem[1]);
    else passed++;
  endtask

  task automatic test_contention();
    int n_acks = 0;
    bit port;
    for (int i = 0; i < 2; i++) begin
      exp_port_q.push_back(1'b0); exp_q.push_back(ref_mem[0]);
      exp_port_q.push_back(1'b1); exp_q.push_back(ref_mem[2]);
    end
    a_addr = 16'h0000; a_req = 1'b1;
    b_addr = 16'h0002; b_we = 1'b0; b_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        n_acks++;
        checks++;
        if (a_ack === 1'b1 && b_ack === 1'b1) $display("FAIL contention_overlap: both acks high at cycle %0d", i);
        else passed++;
        if (exp_port_q.size() != 0) begin
          port = exp_port_q.pop_front();
          checks++;
          if (b_ack !== port) $display("FAIL contention_order: ack %0d got port_b=%b want %b", n_acks, b_ack, port);
          else passed++;
          checks++;
          if ((port ? b_rdata : a_rdata) !== exp_q[0]) $display("FAIL contention_data: ack %0d got %h want %h", n_acks, port ? b_rdata : a_rdata, exp_q[0]);
          else passed++;
          void'(exp_q.pop_front());
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (n_acks !== 4) $display("FAIL contention_ack_count: got %0d want 4", n_acks);
    else passed++;
    exp_port_q.delete();
    exp_q.delete();
    exp_b_rdata = ref_mem[2];
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit got; int lat; logic [BD-1:0] rd; int wc0; int n_acks = 0;
    wc0 = write_cycles;
    b_we = 1'b1; b_addr = 16'h0010; b_wdata = 32'h1234_5678; b_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 16'h0010) $display("FAIL mid_reset_access: mem_write %b addr %h want 1 0010", mem_write, mem_address);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_write, busy, b_ack} !== 3'b000) $display("FAIL mid_reset_clear: got %b want 000", {mem_write, busy, b_ack});
    else passed++;
    b_req = 1'b0; b_we = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_b_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (b_ack === 1'b1 || a_ack === 1'b1) n_acks++;
    end
    checks++;
    if (n_acks !== 0) $display("FAIL mid_reset_no_ack: got %0d acks want 0", n_acks);
    else passed++;
    checks++;
    if (write_cycles !== wc0) $display("FAIL mid_reset_no_commit: %0d write cycles want 0", write_cycles - wc0);
    else passed++;
    exp_q.push_back(ref_mem[32'h10]);
    do_access(1'b1, 1'b0, 16'h0010, '0, got, lat, rd);
    checks++;
    if (rd !== exp_q[0]) $display("FAIL mid_reset_old_value: got %h want %h", rd, exp_q[0]);
    else passed++;
    exp_b_rdata = exp_q.pop_front();
  endtask

  task automatic test_addr_extremes();
    bit got; int lat; logic [BD-1:0] rd;
    do_access(1'b1, 1'b1, 16'hFFFF, 32'hA5A5_A5A5, got, lat, rd);
    ref_mem[32'hFFFF] = 32'hA5A5_A5A5;
    do_access(1'b1, 1'b1, 16'h0000, 32'h5A5A_5A5A, got, lat, rd);
    ref_mem[0] = 32'h5A5A_5A5A;
    checks++;
    if (b_rdata !== exp_b_rdata) $display("FAIL extreme_write_rdata_kept: got %h want %h", b_rdata, exp_b_rdata);
    else passed++;
    exp_q.push_back(ref_mem[32'hFFFF]);
    do_access(1'b1, 1'b0, 16'hFFFF, '0, got, lat, rd);
    checks++;
    if (rd !== exp_q[0]) $display("FAIL extreme_b_read_ffff: got %h want %h", rd, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    exp_q.push_back(ref_mem[0]);
    do_access(1'b0, 1'b0, 16'h0000, '0, got, lat, rd);
    checks++;
    if (rd !== exp_q[0]) $display("FAIL extreme_a_read_0000: got %h want %h", rd, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    exp_q.push_back(ref_mem[32'hFFFF]);
    do_access(1'b0, 1'b0, 16'hFFFF, '0, got, lat, rd);
    checks++;
    if (rd !== exp_q[0]) $display("FAIL extreme_a_read_ffff: got %h want %h", rd, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_single_a_read();
    test_b_write_read();
    test_contention();
    test_mid_reset();
    test_addr_extremes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
